imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Accepts one 32-bit instruction word plus a sideband tag (e.g. PC) per valid/ready handshake.
- Extracts and sign/zero-extends the immediate to XLEN and classifies its format.
- Registered output behind a 2-entry skid buffer: full throughput under backpressure, plus a synchronous flush for branch redirect.

---
 rtl/imm_gen_pkg.sv | 34 +++
 rtl/imm_format_decode.sv | 81 ++++++++
 rtl/imm_gen_pipe.sv | 102 ++++++++++
 tb/tb_imm_gen_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate generator.
// Optional CSR-immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SRL_A = 3'b101;

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_A);
    endfunction

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate extraction and format classification.
// With IMM_GEN_ZICSR_EN defined, SYSTEM opcodes with funct3[2]=1 yield a CSR uimm.
module imm_format_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;

    assign opcode_s = instr_i[6:0];
    assign funct3_s = instr_i[14:12];

    // Opcode-driven immediate selection; unknown opcodes pass through as NONE.
    always_comb begin
        imm_o = '0;
        fmt_o = FMT_NONE;
        case (opcode_s)
            OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                imm_o = XLEN'($signed(instr_i[31:20]));
                fmt_o = FMT_I;
            end
            OPC_OPIMM: begin
                if (is_shift_f3(funct3_s)) begin
                    // funct7/funct6 bits are not part of the shift amount
                    if (XLEN == 64) begin
                        imm_o = XLEN'(instr_i[25:20]);
                    end else begin
                        imm_o = XLEN'(instr_i[24:20]);
                    end
                    fmt_o = FMT_SHAMT;
                end else begin
                    imm_o = XLEN'($signed(instr_i[31:20]));
                    fmt_o = FMT_I;
                end
            end
            OPC_STORE: begin
                imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                       instr_i[11:8], 1'b0}));
                fmt_o = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
                fmt_o = FMT_U;
            end
            OPC_JAL: begin
                imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                       instr_i[30:21], 1'b0}));
                fmt_o = FMT_J;
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (funct3_s[2]) begin
                    imm_o = XLEN'(instr_i[19:15]);
                    fmt_o = FMT_CSR;
                end else begin
                    imm_o = '0;
                    fmt_o = FMT_NONE;
                end
`else
                imm_o = '0;
                fmt_o = FMT_NONE;
`endif
            end
            default: begin
                imm_o = '0;
                fmt_o = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeding an output register (R0) plus skid register (R1).
// Optional CSR decode controlled by IMM_GEN_ZICSR_EN (see imm_format_decode).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, tag: '0};

    logic [XLEN-1:0] dec_imm_s;
    imm_fmt_e        dec_fmt_s;
    entry_t          in_entry_s;
    logic            accept_s;
    logic            r0_free_s;

    entry_t r0_q, r0_d, r1_q, r1_d;
    logic   r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;

    imm_format_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i (in_instr),
        .imm_o   (dec_imm_s),
        .fmt_o   (dec_fmt_s)
    );

    assign in_entry_s = '{imm: dec_imm_s, fmt: dec_fmt_s, tag: in_tag};
    // in_ready comes straight from R1 state, so out_ready never reaches it combinationally
    assign accept_s   = in_valid & ~r1_valid_q;
    assign r0_free_s  = ~r0_valid_q | out_ready;

    // Next-state for the two-entry skid buffer; flush empties both slots and drops the input.
    always_comb begin
        r0_d       = r0_q;
        r1_d       = r1_q;
        r0_valid_d = r0_valid_q;
        r1_valid_d = r1_valid_q;
        if (flush) begin
            r0_valid_d = 1'b0;
            r1_valid_d = 1'b0;
        end else if (r0_free_s) begin
            if (r1_valid_q) begin
                r0_d       = r1_q;
                r0_valid_d = 1'b1;
                r1_valid_d = 1'b0;
            end else if (accept_s) begin
                r0_d       = in_entry_s;
                r0_valid_d = 1'b1;
            end else begin
                r0_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            r1_d       = in_entry_s;
            r1_valid_d = 1'b1;
        end else begin
            r1_valid_d = r1_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_q       <= ENTRY_RST;
            r1_q       <= ENTRY_RST;
            r0_valid_q <= 1'b0;
            r1_valid_q <= 1'b0;
        end else begin
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            r0_valid_q <= r0_valid_d;
            r1_valid_q <= r1_valid_d;
        end
    end

    assign in_ready  = ~r1_valid_q;
    assign out_valid = r0_valid_q;
    assign out_imm   = r0_q.imm;
    assign out_fmt   = r0_q.fmt;
    assign out_tag   = r0_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int TAG_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             rdy32, rdy64, ov32, ov64;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    imm_fmt_e         fmt32, fmt64;
    logic [TAG_W-1:0] tag32, tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64));

    typedef struct {
        logic [31:0]      imm32;
        logic [63:0]      imm64;
        imm_fmt_e         fmt;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    bit   done     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: immediate value computed as a signed integer from field weights.
    function automatic exp_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        exp_t        e;
        longint      v;
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          shamt;
        opc   = ins[6:0];
        f3    = ins[14:12];
        v     = 64'sd0;
        shamt = 1'b0;
        e.fmt = FMT_NONE;
        e.tag = tag;
        if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
            shamt = 1'b1;
            e.fmt = FMT_SHAMT;
        end else if (opc == 7'h03 || opc == 7'h13 || opc == 7'h67 || opc == 7'h0F) begin
            e.fmt = FMT_I;
            v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
        end else if (opc == 7'h23) begin
            e.fmt = FMT_S;
            v = longint'(ins[31:25]) * 64'sd32 + longint'(ins[11:7]) - (ins[31] ? 64'sd4096 : 64'sd0);
        end else if (opc == 7'h63) begin
            e.fmt = FMT_B;
            v = longint'(ins[7]) * 64'sd2048 + longint'(ins[30:25]) * 64'sd32
              + longint'(ins[11:8]) * 64'sd2 - (ins[31] ? 64'sd4096 : 64'sd0);
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.fmt = FMT_U;
            v = longint'(ins[31:12]) * 64'sd4096 - (ins[31] ? (64'sd1 <<< 32) : 64'sd0);
        end else if (opc == 7'h6F) begin
            e.fmt = FMT_J;
            v = longint'(ins[19:12]) * 64'sd4096 + longint'(ins[20]) * 64'sd2048
              + longint'(ins[30:21]) * 64'sd2 - (ins[31] ? 64'sd1048576 : 64'sd0);
        end
`ifdef IMM_GEN_ZICSR_EN
        if (opc == 7'h73 && ins[14]) begin
            e.fmt = FMT_CSR;
            v = longint'(ins[19:15]);
        end
`endif
        e.imm64 = v;
        e.imm32 = v[31:0];
        if (shamt) begin
            e.imm32 = 32'(ins[24:20]);
            e.imm64 = 64'(ins[25:20]);
        end
        return e;
    endfunction

    // Monitor: compare presented outputs with the scoreboard head, then update the occupancy.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit exp_rdy = (sb.size() < 2);
            automatic bit exp_ov  = (sb.size() != 0);
            chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
            chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
            chk("out_valid32", 64'(ov32), 64'(exp_ov));
            chk("out_valid64", 64'(ov64), 64'(exp_ov));
            if (exp_ov) begin
                chk("imm32", 64'(imm32), 64'(sb[0].imm32));
                chk("fmt32", 64'(fmt32), 64'(sb[0].fmt));
                chk("tag32", 64'(tag32), 64'(sb[0].tag));
                chk("imm64", imm64, sb[0].imm64);
                chk("fmt64", 64'(fmt64), 64'(sb[0].fmt));
                chk("tag64", 64'(tag64), 64'(sb[0].tag));
            end
            if (!rst_n || flush) begin
                sb.delete();
            end else begin
                if (exp_ov && out_ready) void'(sb.pop_front());
                if (in_valid && exp_rdy) sb.push_back(model(in_instr, in_tag));
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        @(negedge clk);
        while (!rdy32 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy32) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready=0 for tag %h, required 1", tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [31:0] ins, input logic [TAG_W-1:0] tag,
                            input logic [31:0] e32, input logic [63:0] e64, input imm_fmt_e ef);
        send(ins, tag);
        @(negedge clk);
        chk("dir_valid", 64'(ov32 & ov64), 64'd1);
        chk("dir_imm32", 64'(imm32), 64'(e32));
        chk("dir_imm64", imm64, e64);
        chk("dir_fmt", 64'(fmt32), 64'(ef));
        chk("dir_tag", 64'(tag64), 64'(tag));
        @(posedge clk); #1;
    endtask

    localparam logic [6:0] OPCS [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63,
                                         7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = OPCS[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(ov32 | ov64), 64'd0);
        chk("rst_imm", imm64 | 64'(imm32), 64'd0);
        chk("rst_fmt", 64'(fmt32), 64'(FMT_NONE));
        chk("rst_tag", 64'(tag32 | tag64), 64'd0);
        chk("rst_ready", 64'(rdy32 & rdy64), 64'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        directed(32'hFFF00093, 32'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I);
        directed(32'hFE000EE3, 32'h12, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B);
        directed(32'h4030D093, 32'h13, 32'h00000003, 64'h0000000000000003, FMT_SHAMT);
        directed(32'h800000B7, 32'h14, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U);
        directed(32'h0000007F, 32'h15, 32'h0, 64'h0, FMT_NONE);
`ifdef IMM_GEN_ZICSR_EN
        directed(32'h3402D073, 32'h16, 32'd5, 64'd5, FMT_CSR);
`else
        directed(32'h3402D073, 32'h16, 32'd0, 64'd0, FMT_NONE);
`endif

        // Backpressure: tags 1,2 fill R0/R1, tag 3 waits.
        out_ready = 1'b0;
        send(rand_instr(), 32'd1);
        send(rand_instr(), 32'd2);
        in_valid = 1'b1; in_instr = rand_instr(); in_tag = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_ready", 64'(rdy32), 64'd0);
        chk("bp_tag_held", 64'(tag32), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(in_instr, 32'd3);
        repeat (4) @(posedge clk);
        #1;

        // Flush with both slots full plus a same-cycle input.
        out_ready = 1'b0;
        send(rand_instr(), 32'hA1);
        send(rand_instr(), 32'hA2);
        in_valid = 1'b1; in_instr = rand_instr(); in_tag = 32'hA3; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(ov32 | ov64), 64'd0);
        chk("flush_ready", 64'(rdy32 & rdy64), 64'd1);
        @(posedge clk); #1;
        // Flush with one slot full and an acceptable input.
        send(rand_instr(), 32'hB1);
        in_valid = 1'b1; in_instr = rand_instr(); in_tag = 32'hB2; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-stream with in_valid held.
        out_ready = 1'b0;
        send(rand_instr(), 32'hC1);
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hC2; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(ov32 | ov64), 64'd0);
        chk("mrst_fmt", 64'(fmt64), 64'(FMT_NONE));
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Random traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_instr(), 32'(i + 256));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
